// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data requests onto one shared memory port
module mem_port_arbiter #(
  parameter int BIT_WIDTH    = 32,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // instruction fetch port
  input  logic                 if_req,
  input  logic [BIT_WIDTH-1:0] if_addr,
  output logic                 if_done,
  output logic [BIT_WIDTH-1:0] if_rdata,
  // data (load/store) port
  input  logic                 d_req,
  input  logic                 d_wrt_en,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic                 d_done,
  output logic [BIT_WIDTH-1:0] d_rdata,
  // pipeline stall indications
  output logic                 stall_if,
  output logic                 stall_mem,
  // shared memory port
  output logic                 mem_req,
  output logic                 mem_wrt_en,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [BIT_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] STREAK_LIMIT = 3'(MAX_D_STREAK);
  localparam logic [2:0] STREAK_SAT   = 3'd7;

  state_t     state;
  logic [2:0] d_streak;
  logic       grant_d;
  logic       grant_if;

  // Data normally wins a contested cycle; once it has won STREAK_LIMIT
  // contested grants in a row, fetch gets the port so it cannot starve.
  assign grant_d  = d_req & (~if_req | (d_streak < STREAK_LIMIT));
  assign grant_if = if_req & ~grant_d;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

  // Arbitration FSM: one memory transaction at a time, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      d_streak   <= 3'd0;
      mem_req    <= 1'b0;
      mem_wrt_en <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_wrt_en <= d_wrt_en;
            mem_req    <= 1'b1;
            state      <= D_BUSY;
            // only contested data grants count toward the streak
            if (if_req && (d_streak != STREAK_SAT)) begin
              d_streak <= d_streak + 3'd1;
            end
          end else if (grant_if) begin
            mem_addr   <= if_addr;
            mem_wrt_en <= 1'b0;
            mem_req    <= 1'b1;
            d_streak   <= 3'd0;
            state      <= IF_BUSY;
          end
        end

        IF_BUSY: begin
          if (mem_ack) begin
            if_rdata   <= mem_rdata;
            if_done    <= 1'b1;
            mem_req    <= 1'b0;
            mem_wrt_en <= 1'b0;
            state      <= DONE;
          end
        end

        D_BUSY: begin
          if (mem_ack) begin
            // a store leaves the previously loaded word in place
            if (!mem_wrt_en) begin
              d_rdata <= mem_rdata;
            end
            d_done     <= 1'b1;
            mem_req    <= 1'b0;
            mem_wrt_en <= 1'b0;
            state      <= DONE;
          end
        end

        DONE: begin
          // requests are ignored here so the owner can drop its req
          if_done <= 1'b0;
          d_done  <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_wrt_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_wrt_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.BIT_WIDTH(32), .MAX_D_STREAK(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_wrt_en   (d_wrt_en),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .mem_req    (mem_req),
    .mem_wrt_en (mem_wrt_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cyc = 0;
  int t0;
  int ack_lat = 2;
  int spur_req = 0;
  int spur_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  // Memory model: acks ack_lat cycles after mem_req rises, data = {addr[15:0], C0DE}
  bit seen = 1'b0;
  int acnt = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (spur_req != spur_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        spur_done++;
      end else if (!mem_req) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        acnt = 0;
      end else begin
        acnt++;
        if (acnt == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = {mem_addr[15:0], 16'hC0DE};
        end
      end
    end
  end

  // Monitor: captures the memory transaction at ack, pops and compares at each done
  logic [31:0] cap_addr, cap_wdata, prev_addr, prev_wdata;
  logic        cap_wr, cap_ok = 1'b0, prev_req = 1'b0, prev_wr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("dual_done", 32'(if_done & d_done), 32'd0);
      check("stall_if", 32'(stall_if), 32'(if_req & ~if_done));
      check("stall_mem", 32'(stall_mem), 32'(d_req & ~d_done));
      if (mem_req && prev_req) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wdata", mem_wdata, prev_wdata);
        check("hold_wr", 32'(mem_wrt_en), 32'(prev_wr));
      end
      if (mem_req && mem_ack) begin
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_wr    = mem_wrt_en;
        cap_ok    = 1'b1;
      end
      if (if_done || d_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("owner", 32'(d_done), 32'(e.is_d));
          check("ack_seen", 32'(cap_ok), 32'd1);
          check("mem_addr", cap_addr, e.addr);
          check("mem_wrt_en", 32'(cap_wr), 32'(e.wr));
          if (e.wr) check("mem_wdata", cap_wdata, e.wdata);
          check("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
          done_cyc = cyc;
          cap_ok   = 1'b0;
        end
      end
    end
    prev_req   = mem_req;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_wr    = mem_wrt_en;
  end

  // Waits for n done pulses; requesters drop req in their done cycle unless held
  task automatic wait_dones(input int n, input bit hold);
    int got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (if_done) begin
        got++;
        if (!hold) if_req = 1'b0;
      end
      if (d_done) begin
        got++;
        if (!hold) d_req = 1'b0;
      end
    end
    if (hold) begin
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    if (got < n) check("done_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_wrt_en = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wrt_en", 32'(mem_wrt_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_dones", 32'(if_done | d_done), 32'd0);
    rst_n = 1'b1;

    // fetch only, ack 2 cycles after mem_req -> 4 cycles request to done
    ack_lat = 2;
    @(posedge clk); #1;
    if_addr = 32'h100;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'h0100C0DE));
    t0 = cyc; if_req = 1'b1;
    wait_dones(1, 1'b0);
    @(posedge clk); #1;
    check("fetch_latency", 32'(done_cyc - t0), 32'd4);

    // store, immediate ack -> 3 cycles, d_rdata unchanged (still reset value)
    ack_lat = 1;
    d_wrt_en = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0));
    t0 = cyc; d_req = 1'b1;
    wait_dones(1, 1'b0);
    @(posedge clk); #1;
    check("store_latency", 32'(done_cyc - t0), 32'd3);

    // late data request during IF_BUSY waits for the fetch
    ack_lat = 3;
    if_addr = 32'h200;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0, 32'h0200C0DE));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h80, 32'h0, 32'h0080C0DE));
    if_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d_wrt_en = 1'b0; d_addr = 32'h80; d_wdata = 32'h0; d_req = 1'b1;
    @(negedge clk);
    check("late_addr_hold", mem_addr, 32'h200);
    wait_dones(2, 1'b0);

    // spurious ack in IDLE changes nothing
    repeat (2) @(posedge clk);
    spur_req++;
    repeat (4) @(negedge clk);
    check("spur_if_rdata", if_rdata, 32'h0200C0DE);
    check("spur_d_rdata", d_rdata, 32'h0080C0DE);
    check("spur_mem_req", 32'(mem_req), 32'd0);

    // contention with MAX_D_STREAK=3: D,D,D,IF,D,D,D,IF
    ack_lat = 1;
    if_addr = 32'h300; d_addr = 32'h400; d_wrt_en = 1'b0;
    for (int g = 0; g < 8; g++) begin
      if (g == 3 || g == 7) exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0, 32'h0300C0DE));
      else                  exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0, 32'h0400C0DE));
    end
    @(posedge clk); #1;
    if_req = 1'b1; d_req = 1'b1;
    wait_dones(8, 1'b1);

    // reset during D_BUSY aborts without a done; late ack ignored
    ack_lat = 20;
    @(posedge clk); #1;
    d_wrt_en = 1'b1; d_addr = 32'h44; d_wdata = 32'h12345678; d_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    spur_req++;
    repeat (5) @(negedge clk);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);

    // FSM is back in IDLE: a fresh fetch completes with minimum latency
    ack_lat = 1;
    @(posedge clk); #1;
    if_addr = 32'h500;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h500, 32'h0, 32'h0500C0DE));
    t0 = cyc; if_req = 1'b1;
    wait_dones(1, 1'b0);
    @(posedge clk); #1;
    check("post_abort_latency", 32'(done_cyc - t0), 32'd3);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 32: data and address width.
REQ-002 Parameter MAX_D_STREAK, default 3: consecutive contested data grants allowed before fetch must win (range 1-7).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  fetch stage requests an instruction read; held until if_done.
REQ-006 if_addr  in  BIT_WIDTH  fetch address (PC); stable while if_req is high.
REQ-007 if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  out  BIT_WIDTH  fetched instruction word, registered.
REQ-009 d_req  in  1  MEM stage requests LW/SW access; held until d_done.
REQ-010 d_wrt_en  in  1  1 = store (SW), 0 = load (LW); stable while d_req is high.
REQ-011 d_addr, d_wdata  in  BIT_WIDTH each  data address and store data.
REQ-012 d_done  out  1  one-cycle pulse: data access complete.
REQ-013 d_rdata  out  BIT_WIDTH  load data, registered; valid with d_done when d_wrt_en=0.
REQ-014 stall_if, stall_mem  out  1 each  combinational: stall_if = if_req & ~if_done; stall_mem = d_req & ~d_done.
REQ-015 mem_req  out  1  request to the shared memory, held until mem_ack.
REQ-016 mem_wrt_en  out  1  write strobe qualifying mem_req.
REQ-017 mem_addr, mem_wdata  out  BIT_WIDTH each  registered address and write data.
REQ-018 mem_ack  in  1  memory completion pulse, latency 1 or more cycles after mem_req rises.
REQ-019 mem_rdata  in  BIT_WIDTH  read data, valid in the mem_ack cycle.

Function
REQ-020 FSM states: IDLE, IF_BUSY, D_BUSY, DONE.
REQ-021 IDLE, no requests: remain in IDLE; mem_req=0.
REQ-022 IDLE, only if_req: latch if_addr to mem_addr, set mem_wrt_en=0, set mem_req=1, go to IF_BUSY.
REQ-023 IDLE, only d_req: latch d_addr, d_wdata and d_wrt_en, set mem_req=1, go to D_BUSY.
REQ-024 IDLE, both requests: data wins unless d_streak = MAX_D_STREAK, in which case fetch wins.
REQ-025 d_streak is a 3-bit counter; it increments (saturating) on every data grant made while if_req=1, and clears on every fetch grant.
REQ-026 IF_BUSY/D_BUSY: hold mem_req, mem_addr, mem_wdata and mem_wrt_en stable until mem_ack.
REQ-027 On mem_ack in IF_BUSY or D_BUSY: register mem_rdata into the owner's rdata output, drop mem_req on the next edge, and go to DONE.
REQ-028 DONE: assert the owner's done pulse for exactly one cycle, ignore all requests, return to IDLE; requesters drop req in the done cycle.
REQ-029 Latency: request sampled in IDLE at cycle N gives mem_req high at N+1; mem_ack at cycle M gives done at M+1; minimum request-to-done is 3 cycles.
REQ-030 For a store, d_rdata keeps its previous value.
REQ-031 mem_ack outside IF_BUSY/D_BUSY is ignored and causes no state change.
REQ-032 At most one outstanding memory transaction exists at any time; if_done and d_done are never high together.
REQ-033 A request arriving mid-transaction waits; it is arbitrated in the next IDLE cycle.

Reset
REQ-034 While rst_n=0 at a rising edge: state goes to IDLE; mem_req, mem_wrt_en, if_done and d_done go to 0; mem_addr, mem_wdata, if_rdata and d_rdata go to 0; d_streak goes to 0.
REQ-035 Reset during IF_BUSY/D_BUSY aborts the transaction without a done pulse; a late mem_ack is ignored per REQ-031.

Verification
REQ-036 Fetch only: if_req, if_addr=0x100, mem_ack 2 cycles after mem_req -> mem_addr=0x100, mem_wrt_en=0, if_done pulse with if_rdata=mem_rdata, 4 cycles from request to done.
REQ-037 Store: d_req, d_wrt_en=1, d_addr=0x40, d_wdata=0xDEADBEEF, immediate ack -> mem_wrt_en=1 with mem_wdata=0xDEADBEEF, single d_done pulse, d_rdata unchanged.
REQ-038 Contention: if_req and d_req held continuously with MAX_D_STREAK=3 -> grant order D,D,D,IF,D,D,D,IF; stall_if stays high until each if_done.
REQ-039 Late request: d_req rises during IF_BUSY -> no change to mem_addr; data is granted in the IDLE cycle after DONE.
REQ-040 Reset mid-transaction: rst_n low for 1 cycle during D_BUSY, then mem_ack -> no d_done pulse, FSM in IDLE, mem_req=0.
REQ-041 Spurious ack: mem_ack pulse in IDLE -> no done pulses and no change to rdata outputs.
